// File: rtl/wb_stage.sv
// wb_stage -- writeback stage with a 2-entry in-order retirement buffer.
//
// Results offered by execute/LSU are captured into a small FIFO. Load results
// have their byte/half extracted and extended at capture time, so the buffer
// always holds final register-file data. The head entry is retired (register
// write plus a one-cycle retirement report) every cycle that stall is low.
// Decode can ask whether a register has a buffered, not-yet-written value.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   in_valid / in_ready       upstream handshake; ready iff buffer not full
//   in_pc, in_rd, in_rd_wen   retiring instruction PC, destination, write flag
//   in_is_load, in_ld_size,
//   in_ld_unsigned, in_addr_lo load extraction controls
//   in_result                 ALU result or raw load word
//   stall                     holds retirement; captures continue while room
//   rf_wen/rf_waddr/rf_wdata  register-file write port
//   retire_valid, retire_pc   retirement report
//   q_raddr1/2, hazard1/2     pending-write query for decode

module wb_stage #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_is_load,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  retire_valid,
  output logic [31:0]           retire_pc,
  input  logic [ADDR_WIDTH-1:0] q_raddr1,
  input  logic [ADDR_WIDTH-1:0] q_raddr2,
  output logic                  hazard1,
  output logic                  hazard2
);

  logic [31:0]           pc_q   [2];
  logic [ADDR_WIDTH-1:0] rd_q   [2];
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [1:0]            wen_q;

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  logic push, pop, has_head;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] wdata_in;

  logic [1:0] ent_valid;
  logic [1:0] hit1, hit2;

  // Ready looks only at occupancy, not at a same-cycle pop, so it never
  // depends combinationally on stall.
  assign in_ready = (count_q != 2'd2);
  assign has_head = (count_q != 2'd0);
  assign push     = in_valid && in_ready;
  assign pop      = has_head && !stall;

  // Load extraction: byte lane chosen by both address bits, half lane by
  // bit 1 only; word loads pass straight through.
  always_comb begin
    ld_byte  = in_result[{in_addr_lo, 3'b000} +: 8];
    ld_half  = in_addr_lo[1] ? in_result[31:16] : in_result[15:0];
    wdata_in = in_result;
    if (in_is_load) begin
      case (in_ld_size)
        2'b00:   wdata_in = {{(DATA_WIDTH-8){ld_byte[7] & ~in_ld_unsigned}}, ld_byte};
        2'b01:   wdata_in = {{(DATA_WIDTH-16){ld_half[15] & ~in_ld_unsigned}}, ld_half};
        default: wdata_in = in_result;
      endcase
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful where count marks them valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      wen_q <= '0;
    end else if (push) begin
      pc_q[wr_ptr_q]   <= in_pc;
      rd_q[wr_ptr_q]   <= in_rd;
      data_q[wr_ptr_q] <= wdata_in;
      wen_q[wr_ptr_q]  <= in_rd_wen;
    end
  end

  always_comb begin
    retire_valid = pop;
    retire_pc    = has_head ? pc_q[rd_ptr_q]   : 32'd0;
    rf_waddr     = has_head ? rd_q[rd_ptr_q]   : '0;
    rf_wdata     = has_head ? data_q[rd_ptr_q] : '0;
    rf_wen       = pop && wen_q[rd_ptr_q] && (rd_q[rd_ptr_q] != '0);
  end

  // With one entry the valid slot is the head; with two both slots are live.
  always_comb begin
    ent_valid = '0;
    hit1      = '0;
    hit2      = '0;
    for (int i = 0; i < 2; i++) begin
      ent_valid[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)));
      hit1[i] = ent_valid[i] && wen_q[i] && (rd_q[i] != '0) && (rd_q[i] == q_raddr1);
      hit2[i] = ent_valid[i] && wen_q[i] && (rd_q[i] != '0) && (rd_q[i] == q_raddr2);
    end
    hazard1 = |hit1;
    hazard2 = |hit2;
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [3:0]  in_rd = '0;
  logic        in_rd_wen = 1'b0;
  logic        in_is_load = 1'b0;
  logic [1:0]  in_ld_size = '0;
  logic        in_ld_unsigned = 1'b0;
  logic [1:0]  in_addr_lo = '0;
  logic [31:0] in_result = '0;
  logic        stall = 1'b0;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [3:0]  q_raddr1 = '0;
  logic [3:0]  q_raddr2 = '0;
  logic        hazard1, hazard2;

  wb_stage #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_is_load(in_is_load), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
    .in_result(in_result), .stall(stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .q_raddr1(q_raddr1), .q_raddr2(q_raddr2),
    .hazard1(hazard1), .hazard2(hazard2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  rd;
    logic        wen;
    logic [31:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference value the register file should receive.
  function automatic logic [31:0] ref_wdata(input logic is_load, input logic [1:0] size,
                                            input logic uns, input logic [1:0] lo,
                                            input logic [31:0] res);
    logic [31:0] v;
    if (!is_load) return res;
    if (size == 2'b00) begin
      v = (res >> (8 * lo)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (size == 2'b01) begin
      v = lo[1] ? (res >> 16) : (res & 32'h0000_FFFF);
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    return res;
  endfunction

  // Model: capture accepted results at the clock edge into the scoreboard.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt = 0;
      exp_q.delete();
    end else begin
      bit acc, pp;
      ent_t e;
      acc = in_valid && (cnt < 2);
      pp  = (cnt > 0) && !stall;
      if (acc) begin
        e.pc   = in_pc;
        e.rd   = in_rd;
        e.wen  = in_rd_wen;
        e.data = ref_wdata(in_is_load, in_ld_size, in_ld_unsigned, in_addr_lo, in_result);
        exp_q.push_back(e);
      end
      cnt = cnt + int'(acc) - int'(pp);
    end
  end

  // Monitor: compare DUT outputs against the scoreboard each cycle.
  always @(negedge clk) begin
    bit   exp_ret, h1, h2;
    ent_t hd;
    exp_ret = (cnt > 0) && !stall;
    h1 = 1'b0;
    h2 = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i].wen && exp_q[i].rd != 0 && exp_q[i].rd == q_raddr1) h1 = 1'b1;
      if (exp_q[i].wen && exp_q[i].rd != 0 && exp_q[i].rd == q_raddr2) h2 = 1'b1;
    end
    chk("in_ready", 64'(in_ready), 64'(cnt < 2));
    chk("retire_valid", 64'(retire_valid), 64'(exp_ret));
    chk("hazard1", 64'(hazard1), 64'(h1));
    chk("hazard2", 64'(hazard2), 64'(h2));
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      chk("retire_pc", 64'(retire_pc), 64'(hd.pc));
      chk("rf_waddr", 64'(rf_waddr), 64'(hd.rd));
      chk("rf_wdata", 64'(rf_wdata), 64'(hd.data));
      chk("rf_wen", 64'(rf_wen), 64'(exp_ret && hd.wen && hd.rd != 0));
      if (exp_ret) void'(exp_q.pop_front());
    end else begin
      chk("idle_outputs", {rf_wen, rf_waddr, rf_wdata, retire_pc}, 64'd0);
    end
  end

  task automatic set_in(input logic [31:0] pc, input logic [3:0] rd, input logic wen,
                        input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [1:0] lo, input logic [31:0] res);
    in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rd_wen = wen;
    in_is_load = ld; in_ld_size = sz; in_ld_unsigned = uns;
    in_addr_lo = lo; in_result = res;
  endtask

  // Offer one result and hold it until the edge that accepts it.
  task automatic push_wait(input logic [31:0] pc, input logic [3:0] rd, input logic wen,
                           input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [1:0] lo, input logic [31:0] res);
    int k;
    @(posedge clk); #1;
    set_in(pc, rd, wen, ld, sz, uns, lo, res);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cnt < 2) break;
    end
    if (k == 20) chk("push_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] ld_exp [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                              32'hFFFF_80FF, 32'h0000_7F01};
  logic [1:0]  ld_sz  [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
  logic        ld_un  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0]  ld_lo  [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};

  initial begin
    int nret;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", {rf_wen, retire_valid, hazard1, hazard2, rf_waddr, rf_wdata, retire_pc}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // ALU pass-through
    push_wait(32'h8000_0000, 4'd5, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h1234_5678);
    @(negedge clk);
    chk("alu_wen", 64'(rf_wen), 64'd1);
    chk("alu_waddr", 64'(rf_waddr), 64'd5);
    chk("alu_wdata", 64'(rf_wdata), 64'h1234_5678);
    chk("alu_pc", 64'(retire_pc), 64'h8000_0000);

    // Load extraction table on raw word 0x80FF7F01
    for (int i = 0; i < 5; i++) begin
      push_wait(32'h100 + 32'(4 * i), 4'd9, 1'b1, 1'b1, ld_sz[i], ld_un[i], ld_lo[i], 32'h80FF_7F01);
      @(negedge clk);
      chk("load_wdata", 64'(rf_wdata), 64'(ld_exp[i]));
    end
    push_wait(32'h200, 4'd9, 1'b1, 1'b1, 2'b11, 1'b0, 2'd3, 32'h80FF_7F01);
    @(negedge clk);
    chk("load_word", 64'(rf_wdata), 64'h80FF_7F01);

    // Full buffer under stall, then release
    @(posedge clk); #1;
    stall = 1'b1;
    set_in(32'hA0, 4'd1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h11);
    @(posedge clk); #1;
    set_in(32'hA4, 4'd2, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h22);
    @(posedge clk); #1;
    set_in(32'hA8, 4'd3, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h33);
    @(negedge clk);
    chk("full_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_held", {63'd0, in_ready}, 64'd0);
    chk("stall_no_retire", 64'(retire_valid), 64'd0);
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk);
    chk("order_a", 64'(retire_pc), 64'hA0);
    @(negedge clk);
    chk("order_b", 64'(retire_pc), 64'hA4);
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("order_c", 64'(retire_pc), 64'hA8);
    chk("order_c_wen", 64'(rf_wen), 64'd1);

    // rd=0 and rd_wen=0 retire without writing
    @(posedge clk); #1;
    set_in(32'hB0, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h55);
    @(posedge clk); #1;
    set_in(32'hB4, 4'd3, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h66);
    @(negedge clk);
    chk("x0_retire", {retire_valid, rf_wen}, 64'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("nowen_retire", {retire_valid, rf_wen}, 64'b10);

    // Hazard query
    @(posedge clk); #1;
    stall = 1'b1; q_raddr1 = 4'd7; q_raddr2 = 4'd0;
    push_wait(32'hC0, 4'd7, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h77);
    @(negedge clk);
    chk("hazard_set", {hazard1, hazard2}, 64'b10);
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hazard_clear", 64'(hazard1), 64'd0);

    // Reset with two buffered entries
    @(posedge clk); #1;
    stall = 1'b1;
    push_wait(32'hD0, 4'd4, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h44);
    push_wait(32'hD4, 4'd6, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h66);
    q_raddr1 = 4'd4; q_raddr2 = 4'd6;
    @(negedge clk);
    chk("pre_rst_hazard", {hazard1, hazard2}, 64'b11);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_outputs", {rf_wen, retire_valid, hazard1, hazard2, rf_waddr, rf_wdata, retire_pc}, 64'd0);
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    nret = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (retire_valid || rf_wen) nret++;
    end
    chk("post_rst_no_write", 64'(nret), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid       = ($urandom_range(0, 99) < 60);
      stall          = ($urandom_range(0, 99) < 25);
      in_pc          = $urandom & 32'hFFFF_FFFC;
      in_rd          = 4'($urandom_range(0, 15));
      in_rd_wen      = ($urandom_range(0, 99) < 80);
      in_is_load     = $urandom_range(0, 1) == 1;
      in_ld_size     = 2'($urandom_range(0, 3));
      in_ld_unsigned = $urandom_range(0, 1) == 1;
      in_addr_lo     = 2'($urandom_range(0, 3));
      in_result      = $urandom;
      q_raddr1       = 4'($urandom_range(0, 15));
      q_raddr2       = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; stall = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
